// File: rtl/linear_feed_sr_param.sv
// Parameterised LFSR (Fibonacci or Galois) with free-run and burst stepping.
// Holds a seed reference, counts steps, pulses done at burst end and wrap on return to seed.
//
// Ports:
//   clk        rising-edge clock
//   clear      synchronous active-high reset
//   load       load seed_in (zero replaced by 1) into register and seed reference
//   seed_in    seed value used by load
//   start      begin stepping (sampled in IDLE only)
//   stop       end free-run / abort burst
//   free_run   sampled with start: 1 = free-run, 0 = burst
//   burst_len  sampled with start: number of burst steps
//   lfsr_out   current register state
//   serial_out msb of lfsr_out
//   busy       high while stepping (FREE or BURST)
//   done       one-cycle pulse after the final burst step
//   wrap       one-cycle pulse when a step lands on the seed reference
//   step_cnt   steps since last clear/load/start
module linear_feed_sr_param #(
    parameter int unsigned      WIDTH  = 4,
    parameter logic [WIDTH-1:0] TAPS   = 4'b1100,
    parameter bit               GALOIS = 1'b0,
    parameter logic [WIDTH-1:0] SEED   = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter int unsigned      CW     = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             start,
    input  logic             stop,
    input  logic             free_run,
    input  logic [CW-1:0]    burst_len,
    output logic [WIDTH-1:0] lfsr_out,
    output logic             serial_out,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic [CW-1:0]    step_cnt
);

    if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
        $error("linear_feed_sr_param: WIDTH must be 3..32");
    end

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FREE  = 2'd1;
    localparam logic [1:0] S_BURST = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    // The all-zero state is a lock-up state, so a zero seed is never used.
    localparam logic [WIDTH-1:0] SEED_OK = (SEED == '0) ? ONE : SEED;

    logic [1:0]       state;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] seed_ref;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] seed_fix;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    left;
    logic             done_r;
    logic             wrap_r;

    if (GALOIS) begin : g_galois
        assign step_q = {q[WIDTH-2:0], 1'b0} ^ (q[WIDTH-1] ? TAPS : '0);
    end else begin : g_fib
        assign step_q = {q[WIDTH-2:0], ^(q & TAPS)};
    end

    assign seed_fix = (seed_in == '0) ? ONE : seed_in;

    always_ff @(posedge clk) begin
        if (clear) begin
            state    <= S_IDLE;
            q        <= SEED_OK;
            seed_ref <= SEED_OK;
            cnt      <= '0;
            left     <= '0;
            done_r   <= 1'b0;
            wrap_r   <= 1'b0;
        end else if (load) begin
            state    <= S_IDLE;
            q        <= seed_fix;
            seed_ref <= seed_fix;
            cnt      <= '0;
            done_r   <= 1'b0;
            wrap_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            wrap_r <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt <= '0;
                        if (free_run) begin
                            state <= S_FREE;
                        end else if (burst_len != '0) begin
                            state <= S_BURST;
                            left  <= burst_len;
                        end else begin
                            // Empty burst completes at once without stepping.
                            state  <= S_DONE;
                            done_r <= 1'b1;
                        end
                    end
                end
                S_FREE, S_BURST: begin
                    if (stop) begin
                        state <= S_IDLE;
                    end else begin
                        q      <= step_q;
                        cnt    <= cnt + 1'b1;
                        wrap_r <= (step_q == seed_ref);
                        if (state == S_BURST) begin
                            left <= left - 1'b1;
                            if (left == CW'(1)) begin
                                state  <= S_DONE;
                                done_r <= 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign lfsr_out   = q;
    assign serial_out = q[WIDTH-1];
    assign busy       = (state == S_FREE) || (state == S_BURST);
    assign done       = done_r;
    assign wrap       = wrap_r;
    assign step_cnt   = cnt;

endmodule

// File: doc/linear_feed_sr_param.md
LINEAR_FEED_SR_PARAM -- requirements
Module: linear_feed_sr_param

Interface
REQ-001 Parameter WIDTH, default 4, register length; legal range 3..32.
REQ-002 Parameter TAPS, default 4'b1100 (WIDTH bits); Fibonacci: bit i set = q[i] enters feedback XOR; Galois: XOR mask.
REQ-003 Parameter GALOIS, default 0; 0 = Fibonacci form, 1 = Galois form.
REQ-004 Parameter SEED, default 1 (WIDTH bits, nonzero); value loaded on reset.
REQ-005 Parameter CW, default 16; width of burst_len and step_cnt.
REQ-006 clk  in  1  single clock; all state changes on rising edge.
REQ-007 clear  in  1  synchronous, active-high reset.
REQ-008 load  in  1  load seed_in into the register and seed reference.
REQ-009 seed_in  in  WIDTH  seed value for load.
REQ-010 start  in  1  single-cycle request to begin stepping.
REQ-011 stop  in  1  end free-run stepping.
REQ-012 free_run  in  1  sampled with start; 1 = free-run, 0 = burst.
REQ-013 burst_len  in  CW  sampled with start; number of steps in burst.
REQ-014 lfsr_out  out  WIDTH  current register state.
REQ-015 serial_out  out  1  equals lfsr_out[WIDTH-1] at all times.
REQ-016 busy  out  1  high while in FREE or BURST.
REQ-017 done  out  1  one-cycle pulse at burst completion.
REQ-018 wrap  out  1  one-cycle pulse when the state returns to the seed reference.
REQ-019 step_cnt  out  CW  steps since last reset/load/start.

Function
REQ-020 Fibonacci step: q <= {q[WIDTH-2:0], ^(q & TAPS)}.
REQ-021 Galois step: q <= {q[WIDTH-2:0],1'b0} ^ (q[WIDTH-1] ? TAPS : 0).
REQ-022 FSM states: IDLE, FREE, BURST, DONE; register holds its value in IDLE and DONE.
REQ-023 Priority per edge: clear > load > stop > start > stepping.
REQ-024 load (any state): lfsr_out and seed reference <= seed_in, or 1 if seed_in == 0; step_cnt <= 0; FSM -> IDLE; no done pulse.
REQ-025 start in IDLE: step_cnt <= 0; free_run=1 -> FREE; free_run=0 and burst_len>0 -> BURST; burst_len==0 -> DONE with no step.
REQ-026 start is ignored while busy.
REQ-027 In FREE or BURST, one step per clock starting on the edge after the start edge; step_cnt increments on each step.
REQ-028 Burst: exactly burst_len steps; the state after the final step -> DONE; done=1 and busy=0 for that one cycle; DONE -> IDLE on the next edge.
REQ-029 stop in FREE: -> IDLE on that edge, no step on that edge; stop in BURST aborts -> IDLE with no done; stop in IDLE is ignored.
REQ-030 wrap=1 for the one cycle in which a step has just produced lfsr_out == seed reference.
REQ-031 step_cnt wraps from 2^CW-1 to 0 without a flag.
REQ-032 Zero state is unreachable; a zero seed is replaced by 1.
REQ-033 Outputs are registered, except serial_out and busy, which are decoded from registered state.

Reset
REQ-034 On an edge with clear=1: lfsr_out=SEED, seed reference=SEED, FSM=IDLE, step_cnt=0, done=0, wrap=0, busy=0.
REQ-035 clear mid-burst aborts without a done pulse; clear overrides simultaneous load/start.

Verification
REQ-036 clear high 2 cycles (defaults) -> lfsr_out=0001, serial_out=0, busy=0, done=0, wrap=0, step_cnt=0.
REQ-037 Fibonacci free run from 0001 -> 0010, 0100, 1001, 0011, 0110, 1101, 1010, 0101, 1011, 0111, 1111, 1110, 1100, 1000, 0001; wrap pulses once at step 15; step_cnt=15.
REQ-038 start, free_run=0, burst_len=3 -> 0010, 0100, 1001; done high exactly 1 cycle with busy=0; lfsr_out holds 1001; a second start during the burst is ignored.
REQ-039 load with seed_in=0000 -> lfsr_out=0001; load 1010 mid-free-run -> lfsr_out=1010, FSM IDLE, step_cnt=0.
REQ-040 GALOIS=1, TAPS=4'b1001, burst_len=4 from 0001 -> 0010, 0100, 1000, 1001.
REQ-041 clear at step 2 of a 10-step burst -> next cycle lfsr_out=0001, busy=0, no done pulse; burst_len=0 start -> done pulse, lfsr_out unchanged.
